// File: rtl/stage_memwb_pipe.sv
// stage_memwb_pipe
// MEM/WB pipeline stage. Load data is formatted combinationally, and only the
// final write-back value, rd and reg_write are stored. The stage has a
// valid/ready handshake and a synchronous flush. SKID_EN selects the storage:
// 1 = two-entry skid buffer (M + S) with a registered in_ready.
// 0 = single entry with a combinational in_ready.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid_i / in_ready_o   input handshake from MEM
//   mem_to_reg_i              select load data (1) or ALU result (0)
//   load_funct3_i             LB/LH/LW/LBU/LHU
//   rd_i, reg_write_i         destination register and write enable
//   alu_result_i              ALU result, also the load address
//   mem_rdata_i               raw data-memory read word
//   flush_i                   kill all held entries
//   out_valid_o / out_ready_i output handshake to WB
//   rd_o, wb_data_o           held entry; values are kept while idle
//   reg_write_o               stored reg_write gated by out_valid_o
//
// state | meaning
// EMPTY | no entry held
// ONE   | M valid, drives the outputs
// FULL  | M and S valid; S is younger than M

module stage_memwb_pipe #(
    parameter int DATA_WIDTH  = 32,
    parameter int RADDR_WIDTH = 5,
    parameter bit SKID_EN     = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic                   mem_to_reg_i,
    input  logic [2:0]             load_funct3_i,
    input  logic [RADDR_WIDTH-1:0] rd_i,
    input  logic [DATA_WIDTH-1:0]  alu_result_i,
    input  logic [DATA_WIDTH-1:0]  mem_rdata_i,
    input  logic                   reg_write_i,
    input  logic                   flush_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [RADDR_WIDTH-1:0] rd_o,
    output logic [DATA_WIDTH-1:0]  wb_data_o,
    output logic                   reg_write_o
);

    if (DATA_WIDTH != 32) begin : g_width_check
        $error("stage_memwb_pipe: load formatting requires DATA_WIDTH == 32");
    end

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [7:0]             ld_byte;
    logic [15:0]            ld_half;
    logic [DATA_WIDTH-1:0]  ld_fmt;
    logic [DATA_WIDTH-1:0]  in_wb_data;
    logic                   in_reg_write;

    logic [DATA_WIDTH-1:0]  m_data, s_data;
    logic [RADDR_WIDTH-1:0] m_rd, s_rd;
    logic                   m_we, s_we;

    logic in_xfer, out_xfer;
    logic load_m_in, load_m_s, load_s;

    // Load formatting. Halfword selection ignores address bit 0 on purpose.
    always_comb begin
        case (alu_result_i[1:0])
            2'd0:    ld_byte = mem_rdata_i[7:0];
            2'd1:    ld_byte = mem_rdata_i[15:8];
            2'd2:    ld_byte = mem_rdata_i[23:16];
            default: ld_byte = mem_rdata_i[31:24];
        endcase
        ld_half = alu_result_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (load_funct3_i)
            3'b000:  ld_fmt = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
            3'b100:  ld_fmt = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
            3'b001:  ld_fmt = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
            3'b101:  ld_fmt = {{(DATA_WIDTH-16){1'b0}}, ld_half};
            default: ld_fmt = mem_rdata_i;
        endcase
    end

    assign in_wb_data   = mem_to_reg_i ? ld_fmt : alu_result_i;
    assign in_reg_write = reg_write_i && (rd_i != '0);

    assign out_valid_o = (state != EMPTY);
    assign in_xfer     = in_valid_i && in_ready_o;
    assign out_xfer    = out_valid_o && out_ready_i;

    // With SKID_EN=0, in_ready guarantees that ONE + input transfer always
    // coincides with an output transfer, so FULL is never reached.
    always_comb begin
        state_nxt = state;
        load_m_in = 1'b0;
        load_m_s  = 1'b0;
        load_s    = 1'b0;
        if (flush_i) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        state_nxt = ONE;
                        load_m_in = 1'b1;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        load_m_in = 1'b1;
                    end else if (in_xfer) begin
                        state_nxt = FULL;
                        load_s    = 1'b1;
                    end else if (out_xfer) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        state_nxt = ONE;
                        load_m_s  = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            state  <= (rst) ? EMPTY : state_nxt;
            m_data <= '0;
            m_rd   <= '0;
            m_we   <= 1'b0;
            s_data <= '0;
            s_rd   <= '0;
            s_we   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_m_in) begin
                m_data <= in_wb_data;
                m_rd   <= rd_i;
                m_we   <= in_reg_write;
            end else if (load_m_s) begin
                m_data <= s_data;
                m_rd   <= s_rd;
                m_we   <= s_we;
            end
            if (load_s) begin
                s_data <= in_wb_data;
                s_rd   <= rd_i;
                s_we   <= in_reg_write;
            end
        end
    end

    if (SKID_EN) begin : g_skid
        logic in_ready_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                in_ready_q <= 1'b1;
            end else begin
                in_ready_q <= (state_nxt != FULL);
            end
        end
        assign in_ready_o = in_ready_q;
    end else begin : g_single
        assign in_ready_o = !out_valid_o || out_ready_i;
    end

    assign rd_o        = m_rd;
    assign wb_data_o   = m_data;
    assign reg_write_o = m_we && out_valid_o;

endmodule

// File: tb/tb_stage_memwb_pipe.sv
// Directed bench for stage_memwb_pipe: one skid-mode instance and one
// single-entry instance sharing the data inputs.

module tb_stage_memwb_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic        mem_to_reg;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] alu, rdata;
    logic        reg_write, flush;
    logic        out_valid, out_ready;
    logic [4:0]  rd_out;
    logic [31:0] wb_data;
    logic        reg_write_out;

    logic        in_valid0, in_ready0, out_valid0, out_ready0, reg_write_out0;
    logic [4:0]  rd_out0;
    logic [31:0] wb_data0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stage_memwb_pipe #(.DATA_WIDTH(32), .RADDR_WIDTH(5), .SKID_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .mem_to_reg_i(mem_to_reg), .load_funct3_i(funct3),
        .rd_i(rd), .alu_result_i(alu), .mem_rdata_i(rdata),
        .reg_write_i(reg_write), .flush_i(flush),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .rd_o(rd_out), .wb_data_o(wb_data), .reg_write_o(reg_write_out)
    );

    stage_memwb_pipe #(.DATA_WIDTH(32), .RADDR_WIDTH(5), .SKID_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid0), .in_ready_o(in_ready0),
        .mem_to_reg_i(mem_to_reg), .load_funct3_i(funct3),
        .rd_i(rd), .alu_result_i(alu), .mem_rdata_i(rdata),
        .reg_write_i(reg_write), .flush_i(flush),
        .out_valid_o(out_valid0), .out_ready_i(out_ready0),
        .rd_o(rd_out0), .wb_data_o(wb_data0), .reg_write_o(reg_write_out0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] r, input logic [31:0] a);
        in_valid = v;
        rd       = r;
        alu      = a;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        in_valid = 1'b0; in_valid0 = 1'b0;
        out_ready = 1'b1; out_ready0 = 1'b1;
        mem_to_reg = 1'b0; funct3 = 3'b010;
        rd = '0; alu = '0; rdata = '0; reg_write = 1'b1;

        // Reset / idle
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_reg_write", {31'd0, reg_write_out}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_rd", {27'd0, rd_out}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Load formatting, streamed back to back
        rdata = 32'h80F0_7F81;
        mem_to_reg = 1'b1;
        drive(1'b1, 5'd5, 32'h0000_0100); funct3 = 3'b000;
        tick();
        chk("lb_off0", wb_data, 32'hFFFF_FF81);
        chk("lb_valid", {31'd0, out_valid}, 32'd1);
        drive(1'b1, 5'd5, 32'h0000_0101); funct3 = 3'b100;
        tick();
        chk("lbu_off1", wb_data, 32'h0000_007F);
        drive(1'b1, 5'd5, 32'h0000_0102); funct3 = 3'b001;
        tick();
        chk("lh_off2", wb_data, 32'hFFFF_80F0);
        drive(1'b1, 5'd5, 32'h0000_0103); funct3 = 3'b101;
        tick();
        chk("lhu_off3", wb_data, 32'h0000_80F0);
        drive(1'b1, 5'd5, 32'h0000_0100); funct3 = 3'b010;
        tick();
        chk("lw", wb_data, 32'h80F0_7F81);
        drive(1'b1, 5'd5, 32'h0000_0103); funct3 = 3'b000;
        tick();
        chk("lb_off3", wb_data, 32'hFFFF_FF80);
        drive(1'b1, 5'd5, 32'h0000_0102); funct3 = 3'b100;
        tick();
        chk("lbu_off2", wb_data, 32'h0000_00F0);
        drive(1'b0, 5'd5, 32'h0000_0100);
        tick();
        chk("idle_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_reg_write", {31'd0, reg_write_out}, 32'd0);
        chk("idle_wb_hold", wb_data, 32'h0000_00F0);

        // Streaming and x0 gating
        mem_to_reg = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 5'(i + 1), 32'h10 + 32'(i));
            tick();
            chk("stream_rd", {27'd0, rd_out}, 32'(i + 1));
            chk("stream_data", wb_data, 32'h10 + 32'(i));
            chk("stream_valid", {31'd0, out_valid}, 32'd1);
            chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
        end
        drive(1'b1, 5'd0, 32'h55);
        tick();
        chk("x0_valid", {31'd0, out_valid}, 32'd1);
        chk("x0_reg_write", {31'd0, reg_write_out}, 32'd0);
        chk("x0_data", wb_data, 32'h55);
        drive(1'b0, 5'd0, 32'h0);
        tick();

        // Backpressure: A in M, B in S, C held at the input
        out_ready = 1'b0;
        drive(1'b1, 5'd10, 32'hA0);
        tick();
        chk("bp_a_rd", {27'd0, rd_out}, 32'd10);
        chk("bp_one_ready", {31'd0, in_ready}, 32'd1);
        drive(1'b1, 5'd11, 32'hB0);
        tick();
        chk("bp_full_rd", {27'd0, rd_out}, 32'd10);
        chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
        drive(1'b1, 5'd12, 32'hC0);
        tick();
        chk("bp_stall_rd", {27'd0, rd_out}, 32'd10);
        chk("bp_stall_data", wb_data, 32'hA0);
        chk("bp_stall_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        tick();
        chk("bp_b_rd", {27'd0, rd_out}, 32'd11);
        chk("bp_b_data", wb_data, 32'hB0);
        chk("bp_b_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp_c_rd", {27'd0, rd_out}, 32'd12);
        chk("bp_c_data", wb_data, 32'hC0);
        drive(1'b0, 5'd0, 32'h0);
        tick();
        chk("bp_drain_valid", {31'd0, out_valid}, 32'd0);

        // Flush while FULL, C presented during the flush cycle
        out_ready = 1'b0;
        drive(1'b1, 5'd13, 32'h130);
        tick();
        drive(1'b1, 5'd14, 32'h140);
        tick();
        chk("fl_full_ready", {31'd0, in_ready}, 32'd0);
        drive(1'b1, 5'd15, 32'h150);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_ready", {31'd0, in_ready}, 32'd1);
        chk("fl_wb_clear", wb_data, 32'd0);
        chk("fl_rd_clear", {27'd0, rd_out}, 32'd0);
        drive(1'b0, 5'd0, 32'h0);
        tick();
        chk("fl_c_dropped", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        drive(1'b1, 5'd16, 32'h160);
        tick();
        chk("fl_d_valid", {31'd0, out_valid}, 32'd1);
        chk("fl_d_rd", {27'd0, rd_out}, 32'd16);
        chk("fl_d_data", wb_data, 32'h160);
        drive(1'b0, 5'd0, 32'h0);
        tick();

        // Reset while FULL, with flush in the same cycle
        out_ready = 1'b0;
        drive(1'b1, 5'd17, 32'h170);
        tick();
        drive(1'b1, 5'd18, 32'h180);
        tick();
        chk("rs_full_ready", {31'd0, in_ready}, 32'd0);
        drive(1'b1, 5'd19, 32'h190);
        rst = 1'b1;
        flush = 1'b1;
        tick();
        rst = 1'b0;
        flush = 1'b0;
        drive(1'b0, 5'd0, 32'h0);
        chk("rs_valid", {31'd0, out_valid}, 32'd0);
        chk("rs_ready", {31'd0, in_ready}, 32'd1);
        chk("rs_wb", wb_data, 32'd0);
        chk("rs_rd", {27'd0, rd_out}, 32'd0);
        chk("rs_reg_write", {31'd0, reg_write_out}, 32'd0);
        tick();
        chk("rs_still_empty", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;

        // Single-entry instance: toggling out_ready with a continuous stream
        in_valid0 = 1'b1; out_ready0 = 1'b1; rd = 5'd20; alu = 32'h200;
        #1;
        chk("s0_empty_ready", {31'd0, in_ready0}, 32'd1);
        tick();
        out_ready0 = 1'b0; rd = 5'd21; alu = 32'h210;
        #1;
        chk("s0_stall_ready", {31'd0, in_ready0}, 32'd0);
        chk("s0_x0_rd", {27'd0, rd_out0}, 32'd20);
        tick();
        out_ready0 = 1'b1;
        #1;
        chk("s0_go_ready", {31'd0, in_ready0}, 32'd1);
        chk("s0_x0_hold", {27'd0, rd_out0}, 32'd20);
        tick();
        out_ready0 = 1'b0; rd = 5'd22; alu = 32'h220;
        #1;
        chk("s0_stall2_ready", {31'd0, in_ready0}, 32'd0);
        chk("s0_x1_rd", {27'd0, rd_out0}, 32'd21);
        chk("s0_x1_data", wb_data0, 32'h210);
        tick();
        out_ready0 = 1'b1;
        #1;
        chk("s0_go2_ready", {31'd0, in_ready0}, 32'd1);
        chk("s0_x1_hold", {27'd0, rd_out0}, 32'd21);
        tick();
        in_valid0 = 1'b0;
        #1;
        chk("s0_x2_rd", {27'd0, rd_out0}, 32'd22);
        chk("s0_x2_valid", {31'd0, out_valid0}, 32'd1);
        tick();
        chk("s0_drain_valid", {31'd0, out_valid0}, 32'd0);
        chk("s0_drain_ready", {31'd0, in_ready0}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
